// File: rtl/amm_mem_responder.sv
// Avalon-MM burst memory slave with byte-enable writes and a fixed-latency
// read pipeline; storage survives reset, control state does not.
module amm_mem_responder #(
  parameter int AMM_ADDR_W  = 32,
  parameter int AMM_DATA_W  = 512,
  parameter int AMM_BURST_W = 6,
  parameter int MEM_WORDS_W = 10,
  parameter int RD_LATENCY  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    stall_i,
  input  logic [AMM_ADDR_W-1:0]   amm_address_i,
  input  logic                    amm_read_i,
  input  logic                    amm_write_i,
  input  logic [AMM_DATA_W-1:0]   amm_writedata_i,
  input  logic [AMM_DATA_W/8-1:0] amm_byteenable_i,
  input  logic [AMM_BURST_W-1:0]  amm_burstcount_i,
  output logic                    amm_waitrequest_o,
  output logic [AMM_DATA_W-1:0]   amm_readdata_o,
  output logic                    amm_readdatavalid_o
);

  localparam int DATA_B_W = AMM_DATA_W / 8;
  localparam int ADDR_B_W = $clog2(DATA_B_W);
  localparam int DEPTH    = 1 << MEM_WORDS_W;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [MEM_WORDS_W-1:0]  r_base;
  logic [MEM_WORDS_W-1:0]  w_base_nx;
  logic [AMM_BURST_W-1:0]  r_beat;
  logic [AMM_BURST_W-1:0]  w_beat_nx;
  logic [AMM_BURST_W-1:0]  r_len;
  logic [AMM_BURST_W-1:0]  w_len_nx;
  logic                    r_rdy;

  logic                    w_wait;
  logic                    w_acc_wr;
  logic                    w_acc_rd;
  logic                    w_we;
  logic                    w_issue;
  logic                    w_last;
  logic [MEM_WORDS_W-1:0]  w_cmd_idx;
  logic [MEM_WORDS_W-1:0]  w_off;
  logic [MEM_WORDS_W-1:0]  w_idx;
  logic [MEM_WORDS_W-1:0]  w_wr_idx;
  logic [AMM_BURST_W-1:0]  w_bc;
  logic                    w_unused;

  logic [AMM_DATA_W-1:0]   r_mem [DEPTH];
  logic [AMM_DATA_W-1:0]   r_dat [RD_LATENCY];
  logic [RD_LATENCY-1:0]   r_vld;

  assign w_cmd_idx = amm_address_i[ADDR_B_W +: MEM_WORDS_W];
  assign w_unused  = ^amm_address_i;
  assign w_bc      = (amm_burstcount_i == '0) ?
                     AMM_BURST_W'(1) : amm_burstcount_i;
  assign w_off     = MEM_WORDS_W'(r_beat);
  assign w_idx     = r_base + w_off;
  assign w_last    = (r_beat == r_len - AMM_BURST_W'(1));

  // r_rdy holds waitrequest high until the first edge out of reset
  assign w_wait   = !r_rdy || (r_state == RD_BURST) || stall_i;
  assign w_acc_wr = amm_write_i && !w_wait;
  assign w_acc_rd = amm_read_i && !amm_write_i && !w_wait;

  assign amm_waitrequest_o = w_wait;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_beat  <= '0;
      r_len   <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_base  <= w_base_nx;
      r_beat  <= w_beat_nx;
      r_len   <= w_len_nx;
      r_rdy   <= 1'b1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_base_nx  = r_base;
    w_beat_nx  = r_beat;
    w_len_nx   = r_len;
    w_we       = 1'b0;
    w_issue    = 1'b0;
    w_wr_idx   = w_idx;
    unique case (r_state)
      IDLE: begin
        if (w_acc_wr) begin
          w_we      = 1'b1;
          w_wr_idx  = w_cmd_idx;
          w_base_nx = w_cmd_idx;
          w_len_nx  = w_bc;
          w_beat_nx = AMM_BURST_W'(1);
          if (w_bc > AMM_BURST_W'(1))
            w_state_nx = WR_BURST;
        end else if (w_acc_rd) begin
          w_base_nx  = w_cmd_idx;
          w_len_nx   = w_bc;
          w_beat_nx  = '0;
          w_state_nx = RD_BURST;
        end
      end
      WR_BURST: begin
        if (w_acc_wr) begin
          w_we      = 1'b1;
          w_beat_nx = r_beat + AMM_BURST_W'(1);
          if (w_last)
            w_state_nx = IDLE;
        end
      end
      RD_BURST: begin
        w_issue   = 1'b1;
        w_beat_nx = r_beat + AMM_BURST_W'(1);
        if (w_last)
          w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Storage and read data path carry no reset so contents persist
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int b = 0; b < DATA_B_W; b++) begin
        if (amm_byteenable_i[b])
          r_mem[w_wr_idx][b*8 +: 8] <= amm_writedata_i[b*8 +: 8];
      end
    end
    r_dat[0] <= r_mem[w_idx];
    for (int k = 1; k < RD_LATENCY; k++)
      r_dat[k] <= r_dat[k-1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_issue;
      for (int k = 1; k < RD_LATENCY; k++)
        r_vld[k] <= r_vld[k-1];
    end
  end

  assign amm_readdatavalid_o = r_vld[RD_LATENCY-1];
  assign amm_readdata_o      = r_vld[RD_LATENCY-1] ?
                               r_dat[RD_LATENCY-1] : '0;

endmodule

// File: tb/tb_amm_mem_responder.sv
// Directed bench for amm_mem_responder: bursts, byte enables, wrap,
// stall, read/write collision, pipelined reads and mid-burst reset.
module tb_amm_mem_responder;

  localparam int LAT = 4;

  logic         clk;
  logic         rst_n;
  logic         stall;
  logic [31:0]  addr;
  logic         rd;
  logic         wr;
  logic [511:0] wdata;
  logic [63:0]  be;
  logic [5:0]   bc;
  logic         waitreq;
  logic [511:0] rdata;
  logic         rvalid;

  int checks;
  int errors;
  int f;
  int l;
  logic [511:0] q_rd [$];

  amm_mem_responder #(
    .AMM_ADDR_W (32),
    .AMM_DATA_W (512),
    .AMM_BURST_W(6),
    .MEM_WORDS_W(10),
    .RD_LATENCY (LAT)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .stall_i            (stall),
    .amm_address_i      (addr),
    .amm_read_i         (rd),
    .amm_write_i        (wr),
    .amm_writedata_i    (wdata),
    .amm_byteenable_i   (be),
    .amm_burstcount_i   (bc),
    .amm_waitrequest_o  (waitreq),
    .amm_readdata_o     (rdata),
    .amm_readdatavalid_o(rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_acc(input string tag);
    int n = 0;
    @(negedge clk);
    while (waitreq && n < 32) begin
      n++;
      @(negedge clk);
    end
    chk(tag, waitreq, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // beat i carries d0*(i+1)
  task automatic wr_burst(input logic [31:0] a, input int n, input int cnt,
                          input logic [511:0] d0, input logic [63:0] m,
                          input int stall_beat, input int stall_cyc,
                          input bit also_rd);
    for (int i = 0; i < n; i++) begin
      wr    = 1'b1;
      rd    = also_rd;
      addr  = a;
      bc    = 6'(cnt);
      wdata = d0 * (i + 1);
      be    = m;
      if (i == stall_beat) begin
        stall = 1'b1;
        repeat (stall_cyc) begin
          @(negedge clk);
          chk("stall_wait", waitreq, 1'b1);
          @(posedge clk);
          #1;
        end
        stall = 1'b0;
      end
      wait_acc("wr_acc");
    end
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic rd_issue(input logic [31:0] a, input int cnt);
    rd   = 1'b1;
    addr = a;
    bc   = 6'(cnt);
    wait_acc("rd_acc");
    rd   = 1'b0;
  endtask

  task automatic collect(input int ncyc, output int first, output int last);
    q_rd.delete();
    first = -1;
    last  = -1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (rvalid) begin
        if (first < 0) first = k;
        last = k;
        q_rd.push_back(rdata);
      end else begin
        chk("rdata_zero", rdata, '0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    stall  = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    addr   = '0;
    wdata  = '0;
    be     = '0;
    bc     = '0;

    #3;
    chk("rst_wait", waitreq, 1'b1);
    chk("rst_valid", rvalid, 1'b0);
    chk("rst_data", rdata, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("wait_pre_edge", waitreq, 1'b1);
    @(posedge clk);
    #1;
    chk("wait_post_edge", waitreq, 1'b0);
    stall = 1'b1;
    #1 chk("wait_stall_idle", waitreq, 1'b1);
    stall = 1'b0;
    @(posedge clk);
    #1;

    // burst of 4 at 0x40
    wr_burst(32'h40, 4, 4, 512'h11, '1, -1, 0, 1'b0);
    rd_issue(32'h40, 4);
    collect(12, f, l);
    chk("b4_lat", f, LAT);
    chk("b4_gapless", l - f, 3);
    chk("b4_cnt", q_rd.size(), 4);
    chk("b4_w0", q_rd[0], 512'h11);
    chk("b4_w1", q_rd[1], 512'h22);
    chk("b4_w2", q_rd[2], 512'h33);
    chk("b4_w3", q_rd[3], 512'h44);

    // byte enables
    wr_burst(32'h0, 1, 1, {64{8'hAA}}, '1, -1, 0, 1'b0);
    wr_burst(32'h0, 1, 1, {64{8'h55}}, 64'h1, -1, 0, 1'b0);
    rd_issue(32'h0, 1);
    collect(10, f, l);
    chk("be_cnt", q_rd.size(), 1);
    chk("be_data", q_rd[0], {{63{8'hAA}}, 8'h55});

    // wrap from the top word
    wr_burst(32'hFFC0, 3, 3, 512'hC0DE, '1, -1, 0, 1'b0);
    rd_issue(32'hFFC0, 3);
    collect(12, f, l);
    chk("wrap_cnt", q_rd.size(), 3);
    chk("wrap_w0", q_rd[0], 512'hC0DE);
    chk("wrap_w1", q_rd[1], 512'h181BC);
    chk("wrap_w2", q_rd[2], 512'h2429A);
    rd_issue(32'h0, 1);
    collect(10, f, l);
    chk("wrap_word0", q_rd[0], 512'h181BC);

    // second read issued while first is still in flight
    rd_issue(32'hC0, 1);
    rd_issue(32'h100, 1);
    collect(12, f, l);
    chk("pipe_cnt", q_rd.size(), 2);
    chk("pipe_w0", q_rd[0], 512'h33);
    chk("pipe_w1", q_rd[1], 512'h44);

    // burstcount zero behaves as one
    wr_burst(32'h1C0, 1, 0, 512'h77, '1, -1, 0, 1'b0);
    wr_burst(32'h240, 1, 1, 512'h99, '1, -1, 0, 1'b0);
    rd_issue(32'h1C0, 0);
    collect(12, f, l);
    chk("bc0_cnt", q_rd.size(), 1);
    chk("bc0_w7", q_rd[0], 512'h77);
    rd_issue(32'h240, 1);
    collect(10, f, l);
    chk("bc0_w9", q_rd[0], 512'h99);

    // stall for 5 cycles inside a burst of 8
    wr_burst(32'h400, 8, 8, 512'h1000_0001, '1, 3, 5, 1'b0);
    @(negedge clk);
    chk("stall_idle", waitreq, 1'b0);
    @(posedge clk);
    #1;
    rd_issue(32'h400, 8);
    collect(16, f, l);
    chk("stall_cnt", q_rd.size(), 8);
    chk("stall_w0", q_rd[0], 512'h1000_0001);
    chk("stall_w3", q_rd[3], 512'h4000_0004);
    chk("stall_w4", q_rd[4], 512'h5000_0005);
    chk("stall_w7", q_rd[7], 512'h8000_0008);

    // read and write together: write wins, no response
    wr_burst(32'h140, 1, 1, 512'h5A5A, '1, -1, 0, 1'b1);
    collect(10, f, l);
    chk("rw_noresp", q_rd.size(), 0);
    rd_issue(32'h140, 1);
    collect(10, f, l);
    chk("rw_data", q_rd[0], 512'h5A5A);

    // reset during a 16-word read after 3 issues
    wr_burst(32'h800, 16, 16, 512'hABC, '1, -1, 0, 1'b0);
    rd_issue(32'h800, 16);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_valid", rvalid, 1'b0);
    chk("mrst_wait", waitreq, 1'b1);
    chk("mrst_data", rdata, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_wait_pre", waitreq, 1'b1);
    @(posedge clk);
    #1;
    collect(20, f, l);
    chk("mrst_noresp", q_rd.size(), 0);
    chk("mrst_idle", waitreq, 1'b0);
    rd_issue(32'h800, 2);
    collect(10, f, l);
    chk("mrst_cnt", q_rd.size(), 2);
    chk("mrst_w0", q_rd[0], 512'hABC);
    chk("mrst_w1", q_rd[1], 512'h1578);
    rd_issue(32'hC0, 1);
    collect(10, f, l);
    chk("mrst_old", q_rd[0], 512'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/amm_mem_responder.md
AMM_MEM_RESPONDER -- requirements
Module: amm_mem_responder

Interface
REQ-001 SHALL have parameter AMM_ADDR_W, default 32: byte address width.
REQ-002 SHALL have parameter AMM_DATA_W, default 512: data width; DATA_B_W = AMM_DATA_W/8, ADDR_B_W = log2(DATA_B_W).
REQ-003 SHALL have parameter AMM_BURST_W, default 6: burstcount width.
REQ-004 SHALL have parameter MEM_WORDS_W, default 10: storage depth is 2^MEM_WORDS_W words.
REQ-005 SHALL have parameter RD_LATENCY, default 4 (min 1): cycles from internal read issue to readdatavalid.
REQ-006 SHALL have port clk_i, input, 1 bit: the only clock.
REQ-007 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port stall_i, input, 1 bit: forces waitrequest high when command/beat acceptance is otherwise possible.
REQ-009 SHALL have port amm_address_i, input, AMM_ADDR_W bits: byte address; word index = amm_address_i[ADDR_B_W +: MEM_WORDS_W]; other bits ignored.
REQ-010 SHALL have ports amm_read_i and amm_write_i, inputs, 1 bit each: command strobes.
REQ-011 SHALL have ports amm_writedata_i (AMM_DATA_W) and amm_byteenable_i (DATA_B_W), inputs: write beat data and byte mask.
REQ-012 SHALL have port amm_burstcount_i, input, AMM_BURST_W bits: burst length in words; sampled on the first beat only.
REQ-013 SHALL have port amm_waitrequest_o, output, 1 bit: slave not accepting.
REQ-014 SHALL have ports amm_readdata_o (AMM_DATA_W) and amm_readdatavalid_o (1 bit), outputs: read response.

Function
REQ-015 SHALL implement FSM states IDLE, WR_BURST, RD_BURST.
REQ-016 SHALL drive amm_waitrequest_o = stall_i in IDLE and WR_BURST, and 1 in RD_BURST.
REQ-017 SHALL accept a command or beat only on a cycle with (read or write) high and amm_waitrequest_o low.
REQ-018 SHALL give write priority when amm_read_i and amm_write_i are both high in IDLE (protocol violation; read ignored).
REQ-019 SHALL treat burstcount 0 as 1.
REQ-020 SHALL, on an accepted write in IDLE, latch word index and burstcount, write beat 0, then go to WR_BURST if burstcount > 1, else stay in IDLE.
REQ-021 SHALL, in WR_BURST, write each accepted beat to index base+n (n = beat number), and return to IDLE on the cycle the last beat is accepted.
REQ-022 SHALL update only bytes whose byteenable bit is 1; enable-0 bytes keep prior content.
REQ-023 SHALL, on an accepted read in IDLE, enter RD_BURST on the next cycle, issue one internal word read per cycle for burstcount cycles (index base..base+burstcount-1), then return to IDLE.
REQ-024 SHALL assert amm_readdatavalid_o exactly RD_LATENCY cycles after each internal read issue, one word per cycle, with no gaps within a burst.
REQ-025 SHALL compute index base+n modulo 2^MEM_WORDS_W (wrap at top of storage).
REQ-026 SHALL allow a new command in IDLE while earlier read data is still in the latency pipeline; responses stay in issue order.
REQ-027 SHALL return for a read the data as written by all writes accepted before that read's internal issue cycle.
REQ-028 SHALL ignore stall_i in RD_BURST (internal reads are unaffected).
REQ-029 SHALL drive amm_readdata_o = 0 whenever amm_readdatavalid_o is 0.

Reset
REQ-030 SHALL, while rst_n_i is low, force FSM to IDLE, amm_waitrequest_o = 1, amm_readdatavalid_o = 0, amm_readdata_o = 0, and clear latency-pipeline valids and burst counters.
REQ-031 SHALL drive amm_waitrequest_o = stall_i from the first clk_i edge after rst_n_i deasserts.
REQ-032 SHALL retain storage contents across reset; contents are undefined after power-up.
REQ-033 SHALL, on reset mid-burst, abandon the burst: no further writes, no pending readdatavalid.

Verification
REQ-034 SHALL cover: write burst 4 at address 0x40 (data 0x11..0x44, all enables), read burst 4 at 0x40 -> four valid words 0x11..0x44, first valid RD_LATENCY cycles after RD_BURST entry.
REQ-035 SHALL cover: write 0xAA all bytes at 0x0, then write 0x55 with byteenable bit 0 only -> read returns byte0 = 0x55, bytes 1..63 = 0xAA.
REQ-036 SHALL cover: write burst 3 starting at word 1023 (MEM_WORDS_W=10) -> words 1023, 0, 1 written; read burst 3 from 1023 returns same order.
REQ-037 SHALL cover: stall_i high for 5 cycles during a WR_BURST of 8 -> waitrequest high those cycles, all 8 beats stored, none duplicated.
REQ-038 SHALL cover: read and write both high in IDLE -> write performed, no readdatavalid produced.
REQ-039 SHALL cover: rst_n_i pulsed low during RD_BURST of 16 after 3 issues -> readdatavalid never asserts after reset, FSM in IDLE, previously written data still readable.
